// File: rtl/latch_pipe.sv
// Two-entry skid buffer pipeline register with registered in_ready.
// Optional backpressure counter (stall_cnt port) enabled by LATCH_PIPE_STALL_CNT_EN.
module latch_pipe #(
  parameter int unsigned DATA_W = 71
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
`ifdef LATCH_PIPE_STALL_CNT_EN
  output logic [31:0]       stall_cnt,
`endif
  input  logic              flush
);

  logic              main_valid_q, main_valid_d;
  logic [DATA_W-1:0] main_data_q,  main_data_d;
  logic              skid_valid_q, skid_valid_d;
  logic [DATA_W-1:0] skid_data_q,  skid_data_d;
  logic              in_ready_q,   in_ready_d;
  logic              in_xfer, out_xfer;

  assign in_xfer  = in_valid && in_ready_q;
  assign out_xfer = main_valid_q && out_ready;

  always_comb begin
    main_valid_d = main_valid_q;
    main_data_d  = main_data_q;
    skid_valid_d = skid_valid_q;
    skid_data_d  = skid_data_q;
    if (flush) begin
      main_valid_d = 1'b0;
      skid_valid_d = 1'b0;
    end else if (skid_valid_q) begin
      // in_ready is low whenever skid is full, so only the output side can move
      if (out_xfer) begin
        main_data_d  = skid_data_q;
        skid_valid_d = 1'b0;
      end
    end else if (in_xfer) begin
      if (!main_valid_q || out_xfer) begin
        main_valid_d = 1'b1;
        main_data_d  = in_data;
      end else begin
        skid_valid_d = 1'b1;
        skid_data_d  = in_data;
      end
    end else if (out_xfer) begin
      main_valid_d = 1'b0;
    end
    in_ready_d = !skid_valid_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_valid_q <= 1'b0;
      main_data_q  <= '0;
      skid_valid_q <= 1'b0;
      skid_data_q  <= '0;
      in_ready_q   <= 1'b1;
    end else begin
      main_valid_q <= main_valid_d;
      main_data_q  <= main_data_d;
      skid_valid_q <= skid_valid_d;
      skid_data_q  <= skid_data_d;
      in_ready_q   <= in_ready_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = main_valid_q;
  assign out_data  = main_data_q;

`ifdef LATCH_PIPE_STALL_CNT_EN
  logic [31:0] stall_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_q <= '0;
    end else if (main_valid_q && !out_ready && stall_cnt_q != '1) begin
      stall_cnt_q <= stall_cnt_q + 32'd1;
    end
  end

  assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_latch_pipe.sv
// Scoreboard bench for latch_pipe: directed streaming/skid/flush/reset cases plus random traffic.
module tb_latch_pipe;
  localparam int unsigned DW = 71;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_data;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic          flush;
`ifdef LATCH_PIPE_STALL_CNT_EN
  logic [31:0]   stall_cnt;
  logic [31:0]   exp_stall;
`endif

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;
  logic [DW-1:0] sb_q[$];

  latch_pipe #(.DATA_W(DW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
`ifdef LATCH_PIPE_STALL_CNT_EN
    .stall_cnt (stall_cnt),
`endif
    .flush     (flush)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  // One clock cycle: drive, compare DUT against the scoreboard, then update the model.
  task automatic step(input logic iv, input logic [DW-1:0] id, input logic ordy, input logic fl);
    int unsigned n;
    logic ir;
    @(negedge clk);
    in_valid  = iv;
    in_data   = id;
    out_ready = ordy;
    flush     = fl;
    #1;
    n = sb_q.size();
    check("in_ready", in_ready, n < 2);
    check("out_valid", out_valid, n > 0);
    if (n > 0) check("out_data", out_data, sb_q[0]);
`ifdef LATCH_PIPE_STALL_CNT_EN
    check("stall_cnt", stall_cnt, exp_stall);
`endif
    ir = in_ready;
    out_ready = !ordy;
    #1;
    check("no_comb_path", in_ready, ir);
    out_ready = ordy;
    if (n > 0 && ordy) void'(sb_q.pop_front());
    if (fl) sb_q.delete();
    else if (iv && n < 2) sb_q.push_back(id);
`ifdef LATCH_PIPE_STALL_CNT_EN
    if (n > 0 && !ordy && exp_stall != 32'hFFFF_FFFF) exp_stall++;
`endif
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    in_valid = 1'b0; out_ready = 1'b0; flush = 1'b0; in_data = '0;
    sb_q.delete();
`ifdef LATCH_PIPE_STALL_CNT_EN
    exp_stall = '0;
`endif
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    logic [DW-1:0] rd;
    rst_n = 1'b0;
    in_valid = 1'b0; out_ready = 1'b0; flush = 1'b0; in_data = '0;
`ifdef LATCH_PIPE_STALL_CNT_EN
    exp_stall = '0;
`endif
    repeat (2) @(negedge clk);
    #1;
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_out_data", out_data, '0);
    check("rst_in_ready", in_ready, 1'b1);
    rst_n = 1'b1;

    // streaming 1..4 at full throughput
    for (int i = 1; i <= 4; i++) step(1'b1, DW'(i), 1'b1, 1'b0);
    repeat (2) step(1'b0, '0, 1'b1, 1'b0);

    // skid path: 0xA held, 0xB into skid, then drain
    step(1'b1, DW'(8'hA), 1'b0, 1'b0);
    step(1'b1, DW'(8'hB), 1'b0, 1'b0);
    step(1'b1, DW'(8'hC), 1'b0, 1'b0);
    step(1'b0, '0, 1'b1, 1'b0);
    step(1'b0, '0, 1'b1, 1'b0);
    step(1'b0, '0, 1'b1, 1'b0);

    // flush with both entries full; 0x7 must be discarded
    step(1'b1, DW'(8'h5), 1'b0, 1'b0);
    step(1'b1, DW'(8'h6), 1'b0, 1'b0);
    step(1'b1, DW'(8'h7), 1'b0, 1'b1);
    step(1'b0, '0, 1'b1, 1'b0);
    step(1'b0, '0, 1'b1, 1'b0);

    // asynchronous reset mid-cycle with both entries full
    step(1'b1, DW'(8'h21), 1'b0, 1'b0);
    step(1'b1, DW'(8'h22), 1'b0, 1'b0);
    step(1'b0, '0, 1'b0, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_out_valid", out_valid, 1'b0);
    check("async_out_data", out_data, '0);
    check("async_in_ready", in_ready, 1'b1);
    sb_q.delete();
`ifdef LATCH_PIPE_STALL_CNT_EN
    check("async_stall_cnt", stall_cnt, '0);
    exp_stall = '0;
`endif
    @(negedge clk);
    in_valid = 1'b0; flush = 1'b0;
    rst_n = 1'b1;
    step(1'b1, DW'(8'h33), 1'b1, 1'b0);
    step(1'b0, '0, 1'b1, 1'b0);

`ifdef LATCH_PIPE_STALL_CNT_EN
    do_reset();
    step(1'b1, DW'(8'h44), 1'b0, 1'b0);
    repeat (10) step(1'b0, '0, 1'b0, 1'b0);
    @(negedge clk);
    check("stall_cnt_10", stall_cnt, 32'd10);
    force dut.stall_cnt_q = 32'hFFFF_FFFF;
    #1;
    release dut.stall_cnt_q;
    exp_stall = 32'hFFFF_FFFF;
    step(1'b0, '0, 1'b0, 1'b0);
    step(1'b0, '0, 1'b0, 1'b0);
    step(1'b0, '0, 1'b1, 1'b0);
    @(negedge clk);
    check("stall_cnt_sat", stall_cnt, 32'hFFFF_FFFF);
    step(1'b1, DW'(8'h55), 1'b1, 1'b1);
`endif

    // random valid/ready/flush traffic
    do_reset();
    for (int c = 0; c < 10000; c++) begin
      rd = DW'({$urandom, $urandom, $urandom});
      step(1'($urandom_range(0, 2) != 0), rd, 1'($urandom_range(0, 2) != 0),
           1'($urandom_range(0, 99) == 0));
    end
    repeat (4) step(1'b0, '0, 1'b1, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
